// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 peripheral that owns a small register file.
// Frame = R/W bit (1 = write) + ADDR_W address bits + DATA_W data bits, MSB first.
// Writes commit when cs_n rises, and only if the whole frame arrived.
// The optional read-back path is enabled by defining SPI_READBACK_EN.
module spi_regfile #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk_raw,
  input  logic                         mosi_raw,
  input  logic                         cs_n_raw,
  output logic                         miso,
  output logic                         miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FL    = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FL + 1);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t              state, state_nxt;
  logic                sclk_p0, sclk_p1, sclk_p2;
  logic                mosi_p0, mosi_p1;
  logic                cs_n_p0, cs_n_p1;
  logic [1:0]          rdy_p;
  logic                armed;
  logic                sclk_rise;
  logic [FL-1:0]       shreg;
  logic [CNT_W-1:0]    bitcnt;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                frm_rw;
  logic [ADDR_W-1:0]   frm_addr;
  logic [DATA_W-1:0]   frm_data;
  logic                addr_ok;
  logic                commit;
  logic                discard;

  // Two-flop synchronisers plus one extra SCLK stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      cs_n_p0 <= 1'b1;
      cs_n_p1 <= 1'b1;
    end else begin
      sclk_p0 <= sclk_raw;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= mosi_raw;
      mosi_p1 <= mosi_p0;
      cs_n_p0 <= cs_n_raw;
      cs_n_p1 <= cs_n_p0;
    end
  end

  // Arm frame start only once cs_n has been seen high after reset, so a
  // chip select already low at reset release cannot start a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_p <= 2'b00;
      armed <= 1'b0;
    end else begin
      rdy_p <= {rdy_p[0], 1'b1};
      if (rdy_p[1] && cs_n_p1) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;

  assign frm_rw   = shreg[FL-1];
  assign frm_addr = shreg[FL-2 -: ADDR_W];
  assign frm_data = shreg[DATA_W-1:0];
  assign addr_ok  = ({1'b0, frm_addr} < NREGS);

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, plus commit/discard decisions taken when cs_n rises
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    discard   = 1'b0;
    if (cs_n_p1) begin
      state_nxt = IDLE;
      if (state == DONE)      commit  = frm_rw & addr_ok;
      else if (state != IDLE) discard = (bitcnt != '0);
    end else begin
      case (state)
        IDLE:    if (armed) state_nxt = CMD;
        CMD:     if (sclk_rise && bitcnt == CNT_W'(ADDR_W)) state_nxt = DATA;
        DATA:    if (sclk_rise && bitcnt == CNT_W'(FL - 1)) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Input shifter and bit counter; cleared whenever the FSM (re)enters IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (state_nxt == IDLE) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (sclk_rise && (state == CMD || state == DATA)) begin
      shreg  <= {shreg[FL-2:0], mosi_p1};
      bitcnt <= bitcnt + CNT_W'(1);
    end
  end

  // Register file update and the write/error strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_addr   <= '0;
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_pulse  <= commit;
      frame_err <= discard;
      if (commit) begin
        wr_addr <= frm_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (frm_addr == ADDR_W'(i)) regs[i] <= frm_data;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

`ifdef SPI_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] tx_sh;

  assign sclk_fall = ~sclk_p1 & sclk_p2;

  // Addressed register for read-back; unimplemented addresses read as 0.
  // After 1+ADDR_W bits the low shreg bits hold the address.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shreg[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i];
    end
  end

  // Output shifter: load on the SCLK fall after the last address bit of a
  // read, then shift left on every later fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh <= '0;
    end else if (state_nxt == IDLE) begin
      tx_sh <= '0;
    end else if (sclk_fall) begin
      if (state == DATA && bitcnt == CNT_W'(1 + ADDR_W) && !shreg[ADDR_W])
        tx_sh <= rd_val;
      else
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
    end
  end

  assign miso_oe = (state != IDLE);
  assign miso    = miso_oe & tx_sh[DATA_W-1];
`else
  assign miso    = 1'b0;
  assign miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Testbench for spi_regfile: bit-banged SPI controller, reference register
// model, and queues of expected versus observed committed writes.
module tb_spi_regfile;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                       clk      = 1'b0;
  logic                       rst_n    = 1'b0;
  logic                       sclk_raw = 1'b0;
  logic                       mosi_raw = 1'b0;
  logic                       cs_n_raw = 1'b1;
  logic                       miso;
  logic                       miso_oe;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_pulse;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;

  wr_t                        exp_q[$];
  wr_t                        obs_q[$];
  logic [NUM_REGS*DATA_W-1:0] model_flat = '0;
  int                         err_cnt  = 0;
  int                         n_checks = 0;
  int                         n_pass   = 0;

  spi_regfile #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk_raw  (sclk_raw),
    .mosi_raw  (mosi_raw),
    .cs_n_raw  (cs_n_raw),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: record every committed write and count frame errors
  always @(negedge clk) begin
    if (wr_pulse) begin
      wr_t w;
      w.addr = wr_addr;
      w.data = regs_flat[int'(wr_addr)*DATA_W +: DATA_W];
      obs_q.push_back(w);
    end
    if (frame_err) err_cnt++;
  end

  task automatic expect_wr(input int a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    exp_q.push_back(w);
    model_flat[a*DATA_W +: DATA_W] = d;
  endtask

  // Mode-0 controller: mosi changes while SCLK is low, miso sampled at rise
  task automatic spi_xfer(input logic [31:0] word, input int nbits, input bit raise_cs,
                          output logic [31:0] rx, output logic oe_seen);
    rx = '0;
    oe_seen = 1'b0;
    @(negedge clk);
    cs_n_raw = 1'b0;
    #100;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi_raw = word[i];
      #50;
      rx = {rx[30:0], miso};
      if (i == nbits - 1) oe_seen = miso_oe;
      sclk_raw = 1'b1;
      #50;
      sclk_raw = 1'b0;
    end
    #100;
    if (raise_cs) begin
      cs_n_raw = 1'b1;
      #200;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (regs_flat !== '0) $display("FAIL reset_regs: got %h want 0", regs_flat); else n_pass++;
    n_checks++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %h want 0", wr_addr); else n_pass++;
    n_checks++; if (wr_pulse !== 1'b0) $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
    n_checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso); else n_pass++;
    n_checks++; if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe: got %b want 0", miso_oe); else n_pass++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] rx;
    logic oe;
    wr_t e, o;
    int e0 = err_cnt;
    expect_wr(2, 8'hA5);
    spi_xfer(32'h0000_82A5, 16, 1'b1, rx, oe);
    n_checks++; if (obs_q.size() != 1) $display("FAIL write_pulses: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL write_commit: got addr %h data %h want addr %h data %h", o.addr, o.data, e.addr, e.data); else n_pass++;
    end
    n_checks++; if (wr_addr !== 7'd2) $display("FAIL write_wr_addr: got %h want 2", wr_addr); else n_pass++;
    n_checks++; if (regs_flat !== model_flat) $display("FAIL write_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    n_checks++; if (err_cnt - e0 != 0) $display("FAIL write_frame_err: got %0d want 0", err_cnt - e0); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_addr();
    logic [31:0] rx;
    logic oe;
    int e0 = err_cnt;
    spi_xfer(32'h0000_85FF, 16, 1'b1, rx, oe);
    n_checks++; if (obs_q.size() != 0) $display("FAIL bad_addr_pulses: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (err_cnt - e0 != 0) $display("FAIL bad_addr_frame_err: got %0d want 0", err_cnt - e0); else n_pass++;
    n_checks++; if (regs_flat !== model_flat) $display("FAIL bad_addr_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_short_frame();
    logic [31:0] rx;
    logic oe;
    wr_t e, o;
    int e0 = err_cnt;
    spi_xfer(32'h0000_8133 >> 7, 9, 1'b1, rx, oe);
    n_checks++; if (err_cnt - e0 != 1) $display("FAIL short_frame_err: got %0d want 1", err_cnt - e0); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL short_pulses: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (regs_flat !== model_flat) $display("FAIL short_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    obs_q.delete();
    expect_wr(1, 8'h5A);
    spi_xfer(32'h0000_815A, 16, 1'b1, rx, oe);
    n_checks++; if (obs_q.size() != 1) $display("FAIL recover_pulses: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL recover_commit: got addr %h data %h want addr %h data %h", o.addr, o.data, e.addr, e.data); else n_pass++;
    end
    n_checks++; if (regs_flat !== model_flat) $display("FAIL recover_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    n_checks++; if (err_cnt - e0 != 1) $display("FAIL recover_frame_err: got %0d want 1", err_cnt - e0); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_long_frame();
    logic [31:0] rx;
    logic oe;
    wr_t e, o;
    int e0 = err_cnt;
    expect_wr(4, 8'h3C);
    spi_xfer(32'h000_843CD, 20, 1'b1, rx, oe);
    n_checks++; if (obs_q.size() != 1) $display("FAIL long_pulses: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL long_commit: got addr %h data %h want addr %h data %h", o.addr, o.data, e.addr, e.data); else n_pass++;
    end
    n_checks++; if (regs_flat !== model_flat) $display("FAIL long_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    n_checks++; if (err_cnt - e0 != 0) $display("FAIL long_frame_err: got %0d want 0", err_cnt - e0); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_empty_cs();
    logic [31:0] rx;
    logic oe;
    int e0 = err_cnt;
    spi_xfer(32'h0, 0, 1'b1, rx, oe);
    n_checks++; if (err_cnt - e0 != 0) $display("FAIL empty_frame_err: got %0d want 0", err_cnt - e0); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL empty_pulses: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (regs_flat !== model_flat) $display("FAIL empty_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_readback();
    logic [31:0] rx;
    logic oe;
    logic [7:0] exp_rd1, exp_rd6;
    logic exp_oe;
    int e0 = err_cnt;
`ifdef SPI_READBACK_EN
    exp_rd1 = model_flat[1*DATA_W +: DATA_W];
    exp_oe  = 1'b1;
`else
    exp_rd1 = 8'h00;
    exp_oe  = 1'b0;
`endif
    exp_rd6 = 8'h00;
    spi_xfer(32'h0000_0100, 16, 1'b1, rx, oe);
    n_checks++; if (rx[7:0] !== exp_rd1) $display("FAIL read1_miso: got %h want %h", rx[7:0], exp_rd1); else n_pass++;
    n_checks++; if (oe !== exp_oe) $display("FAIL read1_miso_oe: got %b want %b", oe, exp_oe); else n_pass++;
    spi_xfer(32'h0000_0600, 16, 1'b1, rx, oe);
    n_checks++; if (rx[7:0] !== exp_rd6) $display("FAIL read6_miso: got %h want %h", rx[7:0], exp_rd6); else n_pass++;
    n_checks++; if (miso_oe !== 1'b0) $display("FAIL read_idle_oe: got %b want 0", miso_oe); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL read_pulses: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (err_cnt - e0 != 0) $display("FAIL read_frame_err: got %0d want 0", err_cnt - e0); else n_pass++;
    n_checks++; if (regs_flat !== model_flat) $display("FAIL read_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    logic oe;
    wr_t e, o;
    expect_wr(0, 8'hC3);
    spi_xfer(32'h0000_80C3, 16, 1'b1, rx, oe);
    expect_wr(3, 8'h96);
    spi_xfer(32'h0000_8396, 16, 1'b1, rx, oe);
    n_checks++; if (obs_q.size() != 2) $display("FAIL b2b_pulses: got %0d want 2", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL b2b_commit: got addr %h data %h want addr %h data %h", o.addr, o.data, e.addr, e.data); else n_pass++;
    end
    n_checks++; if (regs_flat !== model_flat) $display("FAIL b2b_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    logic oe;
    wr_t e, o;
    int e0;
    spi_xfer(32'h0000_8077 >> 4, 12, 1'b0, rx, oe);
    @(negedge clk);
    rst_n = 1'b0;
    model_flat = '0;
    exp_q.delete(); obs_q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_cnt;
    #100;
    for (int i = 0; i < 4; i++) begin
      mosi_raw = 1'b1; #50; sclk_raw = 1'b1; #50; sclk_raw = 1'b0;
    end
    #100;
    cs_n_raw = 1'b1;
    #200;
    n_checks++; if (regs_flat !== model_flat) $display("FAIL midreset_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL midreset_pulses: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (err_cnt - e0 != 0) $display("FAIL midreset_frame_err: got %0d want 0", err_cnt - e0); else n_pass++;
    obs_q.delete();
    expect_wr(0, 8'h11);
    spi_xfer(32'h0000_8011, 16, 1'b1, rx, oe);
    n_checks++; if (obs_q.size() != 1) $display("FAIL postreset_pulses: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL postreset_commit: got addr %h data %h want addr %h data %h", o.addr, o.data, e.addr, e.data); else n_pass++;
    end
    n_checks++; if (regs_flat !== model_flat) $display("FAIL postreset_regs: got %h want %h", regs_flat, model_flat); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_short_frame();
    test_long_frame();
    test_empty_cs();
    test_readback();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning address field width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, meaning register and data field width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 5, meaning implemented registers, 1..2^ADDR_W.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sclk_raw  input  1  SPI clock, asynchronous to clk.
REQ-007 SHALL have port mosi_raw  input  1  SPI controller data out, asynchronous to clk.
REQ-008 SHALL have port cs_n_raw  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-009 SHALL have port miso  output  1  SPI peripheral data out.
REQ-010 SHALL have port miso_oe  output  1  miso drive enable, high while selected.
REQ-011 SHALL have port regs_flat  output  NUM_REGS*DATA_W  register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port wr_pulse  output  1  one-clk pulse on each committed write.
REQ-013 SHALL have port wr_addr  output  ADDR_W  address of the last committed write.
REQ-014 SHALL have port frame_err  output  1  one-clk pulse on each discarded frame.

Function
REQ-015 SHALL synchronise sclk_raw, mosi_raw, cs_n_raw through two flops each; cs_n synchroniser resets to 1 (deselected).
REQ-016 SHALL detect SCLK rising/falling edges from the synchronised SCLK and one further delayed copy; correct operation requires clk >= 8x SCLK.
REQ-017 SHALL use SPI mode 0: sample mosi on SCLK rise, update miso on SCLK fall.
REQ-018 SHALL use frame = 1 R/W bit (1 = write) + ADDR_W address bits + DATA_W data bits, all MSB first; frame length FL = 1+ADDR_W+DATA_W (16 at defaults).
REQ-019 SHALL implement FSM IDLE -> CMD on cs_n falling; CMD -> DATA after 1+ADDR_W rising edges; DATA -> DONE after DATA_W further rising edges; any state -> IDLE on cs_n high.
REQ-020 SHALL ignore SCLK edges in DONE (over-long frames keep the captured data).
REQ-021 SHALL commit a write on cs_n rising only from DONE with R/W = 1 and address < NUM_REGS: register updated, wr_pulse high and wr_addr loaded in the same clk.
REQ-022 SHALL discard a write to address >= NUM_REGS silently, with no wr_pulse and no frame_err.
REQ-023 SHALL discard a frame ended on cs_n rising in CMD or DATA with at least one bit received: no register change, frame_err pulses one clk.
REQ-024 SHALL treat a cs_n low/high pulse with zero SCLK rising edges as a no-op with no frame_err.
REQ-025 SHALL clear the bit counter and shift register on every entry to IDLE; bit counter width is clog2(FL+1).
REQ-026 SHALL drive miso_oe = 1 in CMD/DATA/DONE and 0 in IDLE; miso = 0 whenever miso_oe = 0.
REQ-027 SHALL keep registers, wr_addr, and regs_flat unchanged by read frames.

Reset
REQ-028 SHALL, while rst_n is low, clear all registers, wr_addr, shift register, and bit counter to 0; drive wr_pulse, frame_err, miso, miso_oe to 0; put the FSM in IDLE.
REQ-029 SHALL abandon a frame in progress when reset is asserted mid-frame, with no commit and no frame_err after release.
REQ-030 SHALL not start a frame after reset release while cs_n is already low; the first frame starts at the next cs_n falling edge.

Configuration
REQ-031 SHALL, with SPI_READBACK_EN defined, on a read frame (R/W = 0), load the addressed register (0 if address >= NUM_REGS) into the output shifter at the SCLK fall following the last address bit, and shift miso out MSB first on each following SCLK fall.
REQ-032 SHALL, with SPI_READBACK_EN undefined, hold miso at 0 and miso_oe at 0 permanently; read frames complete with no effect and no frame_err.

Verification
REQ-033 SHALL cover: write 0x80|0x02, 0xA5 (addr 2) -> regs_flat[23:16] = 0xA5, wr_pulse once, wr_addr = 2, other registers 0.
REQ-034 SHALL cover: write addr 0x05 data 0xFF at NUM_REGS = 5 -> no register change, no wr_pulse, no frame_err.
REQ-035 SHALL cover: cs_n raised after 9 SCLK bits of a write -> registers unchanged, frame_err pulses once; next valid frame commits normally.
REQ-036 SHALL cover: 20 SCLK bits with write addr 4 data 0x3C first -> reg4 = 0x3C; the 4 extra bits are ignored.
REQ-037 SHALL cover (SPI_READBACK_EN): write reg1 = 0x5A, then read addr 1 -> miso bits in data phase are 0,1,0,1,1,0,1,0, and reg1 remains 0x5A.
REQ-038 SHALL cover: rst_n asserted after 12 bits of a write to reg0 -> reg0 = 0 after release, no wr_pulse, no frame_err.
